store_buffer_ctrl: RTL

Store buffer and data-memory write-port scheduler between the store pipeline register and the single-port data memory. It accepts registered stores, converts size and byte offset into byte enables and lane-aligned data, and queues them in a small FIFO. The queue drains to memory in cycles the load path leaves free. It forwards buffered bytes to younger loads and supports a fence-style flush.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/store_lane_gen.sv | 40 ++++
 rtl/store_buffer_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory store path: size codes, buffered lane
// payload and the flush sequencing states.
package dmem_pkg;

  localparam logic [2:0] SIZE_B = 3'b000;
  localparam logic [2:0] SIZE_H = 3'b001;
  localparam logic [2:0] SIZE_W = 3'b010;

  typedef struct packed {
    logic [3:0]  be;
    logic [31:0] data;
  } sb_lanes_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FENCE = 2'd1,
    ST_DONE  = 2'd2
  } sb_state_e;

endpackage

// File: rtl/store_lane_gen.sv
// Converts store size and byte offset into byte enables and lane-replicated
// write data; flags misaligned half/word stores and unknown size codes.
module store_lane_gen
  import dmem_pkg::*;
(
  input  logic [2:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_data,
  output sb_lanes_t   o_lanes,
  output logic        o_legal,
  output logic        o_misalign
);

  always_comb begin
    o_lanes    = '0;
    o_legal    = 1'b0;
    o_misalign = 1'b0;
    case (i_size)
      SIZE_B: begin
        o_legal       = 1'b1;
        o_lanes.be    = 4'b0001 << i_off;
        o_lanes.data  = {4{i_data[7:0]}};
      end
      SIZE_H: begin
        o_legal       = 1'b1;
        o_misalign    = i_off[0];
        o_lanes.be    = i_off[1] ? 4'b1100 : 4'b0011;
        o_lanes.data  = {2{i_data[15:0]}};
      end
      SIZE_W: begin
        o_legal       = 1'b1;
        o_misalign    = |i_off;
        o_lanes.be    = 4'b1111;
        o_lanes.data  = i_data;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/store_buffer_ctrl.sv
// Store buffer between the store pipeline and the single-port data memory:
// FIFO of aligned stores, drain into load-free cycles, load forwarding, fence.
//   state    | meaning
//   ST_RUN   | accepting stores, draining when the port is free
//   ST_FENCE | stores blocked, draining until the buffer is empty
//   ST_DONE  | flush complete, stores blocked until flush_req drops
module store_buffer_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_st_valid,
  input  logic [AW-1:0] i_st_addr,
  input  logic [1:0]    i_st_off,
  input  logic [2:0]    i_st_size,
  input  logic [31:0]   i_st_data,
  output logic          o_st_ready,
  input  logic          i_ld_valid,
  input  logic [AW-1:0] i_ld_addr,
  output logic [3:0]    o_ld_fwd_mask,
  output logic [31:0]   o_ld_fwd_data,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [3:0]    o_mem_be,
  output logic [31:0]   o_mem_wdata,
  input  logic          i_flush_req,
  output logic          o_flush_done,
  output logic          o_misalign_err,
  output logic          o_empty,
  output logic          o_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_state_e     r_state;
  logic          r_flush_done;
  logic          r_misalign;
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [AW-1:0] r_addr [DEPTH];
  sb_lanes_t     r_ent  [DEPTH];

  sb_lanes_t     w_lanes;
  logic          w_legal;
  logic          w_mis;
  logic          w_push;
  logic          w_pop;
  logic          w_empty_next;
  logic [PW-1:0] w_fidx;

  store_lane_gen u_lane_gen (
    .i_size     (i_st_size),
    .i_off      (i_st_off),
    .i_data     (i_st_data),
    .o_lanes    (w_lanes),
    .o_legal    (w_legal),
    .o_misalign (w_mis)
  );

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == CW'(DEPTH));
  assign o_st_ready = !o_full && (r_state == ST_RUN);

  assign w_push = i_st_valid && o_st_ready && w_legal && !w_mis;
  assign w_pop  = !o_empty && !i_ld_valid;

  // The reset cycle must never reach memory, even with a valid head entry.
  assign o_mem_we    = w_pop && !rst;
  assign o_mem_addr  = o_empty ? '0 : r_addr[r_head];
  assign o_mem_be    = o_empty ? '0 : r_ent[r_head].be;
  assign o_mem_wdata = o_empty ? '0 : r_ent[r_head].data;

  assign o_flush_done   = r_flush_done;
  assign o_misalign_err = r_misalign;

  // No pushes happen in FENCE, so emptiness after this edge depends on the pop only.
  assign w_empty_next = o_empty || ((r_count == CW'(1)) && w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= i_st_addr;
      r_ent[r_tail]  <= w_lanes;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Walk oldest to youngest so the youngest matching entry wins each lane.
  always_comb begin
    o_ld_fwd_mask = '0;
    o_ld_fwd_data = '0;
    w_fidx        = r_head;
    if (i_ld_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        w_fidx = r_head + PW'(i);
        if ((CW'(i) < r_count) && (r_addr[w_fidx] == i_ld_addr)) begin
          for (int b = 0; b < 4; b++) begin
            if (r_ent[w_fidx].be[b]) begin
              o_ld_fwd_mask[b]        = 1'b1;
              o_ld_fwd_data[8*b +: 8] = r_ent[w_fidx].data[8*b +: 8];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_flush_done <= 1'b0;
      r_misalign   <= 1'b0;
    end else begin
      r_flush_done <= 1'b0;
      r_misalign   <= i_st_valid && o_st_ready && w_legal && w_mis;
      case (r_state)
        ST_RUN: begin
          if (i_flush_req) r_state <= ST_FENCE;
        end
        ST_FENCE: begin
          if (w_empty_next) begin
            r_flush_done <= 1'b1;
            r_state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!i_flush_req) r_state <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

endmodule
